vga_sync_decoder: RTL

// - Receive end of the 640x480@60 VGA interface: takes HS/VS/12-bit colour from a VGA source, checks timing, recovers pixel X/Y.
// - Lets a self-test bench or loopback path check frames generated by the display logic, and supplies pixel addresses to capture logic.
// - Runs on the 100 MHz system clock and samples on a one-cycle pixel strobe (25 MHz).

---
 rtl/vga_sync_decoder.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive side of a 640x480@60 VGA link. HS/VS and RGB444 colour arrive from a
// VGA source together with a one-cycle pixel strobe on the 100 MHz CLK domain.
// The block does four things:
//   - synchronises HS/VS and finds their leading edges,
//   - checks line length and frame height,
//   - locks after LOCK_FRAMES consecutive good frames,
//   - while locked, outputs each active pixel with its X/Y address.
//
// Optional feature: define VGA_DECODE_CHECKSUM_EN to build a per-frame colour
// checksum on FRAME_SUM. Without the macro, FRAME_SUM is tied to zero.
//
// Ports
//   CLK          in   system clock
//   RESET_N      in   asynchronous active-low reset
//   PIX_EN       in   one-cycle pixel strobe (1-in-4)
//   HS, VS       in   sync inputs, asynchronous to CLK
//   COLOUR_IN    in   RGB444 pixel, qualified by PIX_EN
//   LOCKED       out  timing lock established
//   PIX_VALID    out  one-cycle pulse per active pixel while locked
//   X_ADDR       out  active column, valid with PIX_VALID
//   Y_ADDR       out  active row, valid with PIX_VALID
//   COLOUR_OUT   out  colour aligned to X_ADDR/Y_ADDR
//   FRAME_START  out  pulse at a VS leading edge that starts a locked frame
//   LOCK_LOST    out  pulse on the LOCKED->SEARCH transition
//   ERR_COUNT    out  timing errors seen while locked, saturating
//   FRAME_SUM    out  per-frame colour checksum (zero unless enabled)
//   FSM_STATE    out  current FSM state: 0 SEARCH, 1 MEASURE, 2 LOCKED
//
// Handshake: there is no backpressure on either side. PIX_EN qualifies
// COLOUR_IN for one cycle. PIX_VALID qualifies X_ADDR/Y_ADDR/COLOUR_OUT for one
// cycle. Between pulses the address and colour outputs hold their last values.
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int   H_TOTAL     = 800,
  parameter int   H_ACT_START = 144,
  parameter int   H_ACTIVE    = 640,
  parameter int   V_TOTAL     = 525,
  parameter int   V_ACT_START = 35,
  parameter int   V_ACTIVE    = 480,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PIX_EN,
  input  logic        HS,
  input  logic        VS,
  input  logic [11:0] COLOUR_IN,
  output logic        LOCKED,
  output logic        PIX_VALID,
  output logic [9:0]  X_ADDR,
  output logic [9:0]  Y_ADDR,
  output logic [11:0] COLOUR_OUT,
  output logic        FRAME_START,
  output logic        LOCK_LOST,
  output logic [7:0]  ERR_COUNT,
  output logic [15:0] FRAME_SUM,
  output logic [1:0]  FSM_STATE
);

  // h_cnt must hold 0..2*H_TOTAL and line_cnt must hold 0..2*V_TOTAL.
  localparam int HW = $clog2(2 * H_TOTAL + 1);
  localparam int LW = $clog2(2 * V_TOTAL + 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // Sync path: 2-flop synchroniser, an edge register, and a registered
  // edge pulse. The pixel strobe and colour are delayed by the same 3 cycles,
  // so an edge and the pixel that caused it are seen together.
  // -------------------------------------------------------------------------
  logic        hs_s1, hs_s2, hs_q, hs_edge_r;
  logic        vs_s1, vs_s2, vs_q, vs_edge_r;
  logic [2:0]  pe_d;
  logic [11:0] col_d1, col_d2, col_d3;
  logic        pe3;

  assign pe3 = pe_d[2];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // Reset to the idle (deasserted) level so that no edge is seen at release.
      hs_s1     <= ~SYNC_POL;
      hs_s2     <= ~SYNC_POL;
      hs_q      <= ~SYNC_POL;
      vs_s1     <= ~SYNC_POL;
      vs_s2     <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      hs_edge_r <= 1'b0;
      vs_edge_r <= 1'b0;
      pe_d      <= '0;
      col_d1    <= '0;
      col_d2    <= '0;
      col_d3    <= '0;
    end else begin
      hs_s1     <= HS;
      hs_s2     <= hs_s1;
      hs_q      <= hs_s2;
      vs_s1     <= VS;
      vs_s2     <= vs_s1;
      vs_q      <= vs_s2;
      hs_edge_r <= (hs_s2 == SYNC_POL) && (hs_q != SYNC_POL);
      vs_edge_r <= (vs_s2 == SYNC_POL) && (vs_q != SYNC_POL);
      pe_d      <= {pe_d[1:0], PIX_EN};
      col_d1    <= COLOUR_IN;
      col_d2    <= col_d1;
      col_d3    <= col_d2;
    end
  end

  // -------------------------------------------------------------------------
  // Counters and timing checks (combinational next-state)
  // -------------------------------------------------------------------------
  logic [HW-1:0] h_cnt, h_nxt;
  logic          h_pending, h_pending_nxt;
  logic [LW-1:0] line_cnt, line_nxt;
  logic          frame_line_err, frame_line_err_nxt;
  logic          timeout, line_err, frame_err, any_err;
  logic          pix_nxt;

  always_comb begin
    h_nxt         = h_cnt;
    h_pending_nxt = h_pending;
    timeout       = 1'b0;
    if (pe3) begin
      // The pixel that coincides with, or first follows, an HS edge is count 0.
      if (hs_edge_r || h_pending) begin
        h_nxt         = '0;
        h_pending_nxt = 1'b0;
      end else if (int'(h_cnt) == 2 * H_TOTAL - 2) begin
        // The count would reach 2*H_TOTAL-1 with no HS edge: line timeout.
        h_nxt   = '0;
        timeout = 1'b1;
      end else if (int'(h_cnt) < 2 * H_TOTAL) begin
        h_nxt = h_cnt + 1'b1;
      end
    end else if (hs_edge_r) begin
      h_pending_nxt = 1'b1;
    end

    line_nxt = line_cnt;
    if (vs_edge_r) begin
      line_nxt = '0;
    end else if (hs_edge_r && (int'(line_cnt) < 2 * V_TOTAL)) begin
      line_nxt = line_cnt + 1'b1;
    end

    // The line check runs before the frame check, so a line error seen on the
    // same cycle as a VS edge still fails the frame that is ending.
    line_err  = (hs_edge_r && (int'(h_cnt) != H_TOTAL - 1)) || timeout;
    frame_err = vs_edge_r &&
                ((int'(line_cnt) != V_TOTAL - 1) || frame_line_err || line_err);
    any_err   = line_err || frame_err;
    frame_line_err_nxt = vs_edge_r ? 1'b0 : (frame_line_err || line_err);

    pix_nxt = (state == ST_LOCKED) && !any_err && pe3 &&
              (int'(h_nxt) >= H_ACT_START) &&
              (int'(h_nxt) < H_ACT_START + H_ACTIVE) &&
              (int'(line_nxt) >= V_ACT_START) &&
              (int'(line_nxt) < V_ACT_START + V_ACTIVE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt          <= '0;
      h_pending      <= 1'b0;
      line_cnt       <= '0;
      frame_line_err <= 1'b0;
      PIX_VALID      <= 1'b0;
      X_ADDR         <= '0;
      Y_ADDR         <= '0;
      COLOUR_OUT     <= '0;
    end else begin
      h_cnt          <= h_nxt;
      h_pending      <= h_pending_nxt;
      line_cnt       <= line_nxt;
      frame_line_err <= frame_line_err_nxt;
      PIX_VALID      <= pix_nxt;
      if (pix_nxt) begin
        X_ADDR     <= 10'(int'(h_nxt) - H_ACT_START);
        Y_ADDR     <= 10'(int'(line_nxt) - V_ACT_START);
        COLOUR_OUT <= col_d3;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock FSM
  // -------------------------------------------------------------------------
  logic [3:0] good_frames;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_SEARCH;
      good_frames <= '0;
      LOCKED      <= 1'b0;
      FRAME_START <= 1'b0;
      LOCK_LOST   <= 1'b0;
      ERR_COUNT   <= '0;
    end else begin
      FRAME_START <= 1'b0;
      LOCK_LOST   <= 1'b0;
      case (state)
        ST_SEARCH: begin
          LOCKED <= 1'b0;
          if (vs_edge_r) begin
            state       <= ST_MEASURE;
            good_frames <= '0;
          end
        end
        ST_MEASURE: begin
          if (any_err) begin
            state       <= ST_SEARCH;
            good_frames <= '0;
            LOCKED      <= 1'b0;
          end else if (vs_edge_r) begin
            good_frames <= good_frames + 4'd1;
            if (int'(good_frames) + 1 == LOCK_FRAMES) begin
              // The frame that starts at this edge is already a locked frame.
              state       <= ST_LOCKED;
              LOCKED      <= 1'b1;
              FRAME_START <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (any_err) begin
            state       <= ST_SEARCH;
            good_frames <= '0;
            LOCKED      <= 1'b0;
            LOCK_LOST   <= 1'b1;
            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
          end else begin
            LOCKED <= 1'b1;
            if (vs_edge_r) FRAME_START <= 1'b1;
          end
        end
        default: begin
          state       <= ST_SEARCH;
          good_frames <= '0;
          LOCKED      <= 1'b0;
        end
      endcase
    end
  end

  assign FSM_STATE = state;

  // -------------------------------------------------------------------------
  // Optional per-frame colour checksum
  // -------------------------------------------------------------------------
`ifdef VGA_DECODE_CHECKSUM_EN
  logic [15:0] sum_acc, sum_add;

  // Include the pixel presented this cycle so that no pulse is lost at a VS edge.
  assign sum_add = sum_acc + (PIX_VALID ? {4'h0, COLOUR_OUT} : 16'h0000);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sum_acc   <= '0;
      FRAME_SUM <= '0;
    end else if (vs_edge_r) begin
      FRAME_SUM <= sum_add;
      sum_acc   <= '0;
    end else begin
      sum_acc <= sum_add;
    end
  end
`else
  assign FRAME_SUM = 16'h0000;
`endif

endmodule
